mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares one single-ported unified memory between the instruction-fetch stage and the load/store stage of the mips_processor datapath. Each requester presents a level request held until a one-cycle valid response. The arbiter serializes accesses through a small FSM, gives data accesses priority with a starvation guard for fetch, and flags misaligned or timed-out accesses.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch is pending before fetch is forced (1..15).
- `TIMEOUT`, 16: maximum `GRANT_*` cycles without `mem_ready` before abort (2..255).
- `ERR_DATA`, 32'hDEADBEEF: read data returned on an error response.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, level, held until `if_valid`.
- `if_addr` in 32: fetch byte address.
- `if_rdata` out 32: fetched instruction, valid with `if_valid`.
- `if_valid` out 1: one-cycle fetch response.
- `if_err` out 1: fetch error, qualified by `if_valid`.
- `d_req` in 1: data request, level, held until `d_valid`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data, valid with `d_valid`.
- `d_valid` out 1: one-cycle data response.
- `d_err` out 1: data error, qualified by `d_valid`.
- `mem_en` out 1: memory command active, held until `mem_ready`.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid with `mem_ready`.
- `mem_ready` in 1: memory completion, 1 cycle, only while `mem_en`.

## Operation
- States: `IDLE`, `GRANT_IF`, `GRANT_D`, `RESP_IF`, `RESP_D`. The FSM samples `if_req`/`d_req` only in `IDLE`.
- `IDLE` with no request: stay in `IDLE`.
- `IDLE`, `d_req` only: go to `GRANT_D`.
- `IDLE`, `if_req` only: go to `GRANT_IF`.
- `IDLE`, both pending: go to `GRANT_D`, unless `starve_cnt == STARVE_LIMIT`, then go to `GRANT_IF`.
- `starve_cnt` (4 bits):
  - increments on a data grant while `if_req` = 1;
  - clears on any fetch grant, or on a data grant with `if_req` = 0;
  - saturates at `STARVE_LIMIT`.
- On grant, register the address, `d_we` and `d_wdata`. `mem_addr` = {addr[31:2], 2'b00}. `mem_we` = `d_we` for data grants and 0 for fetch.
- Misaligned data access (`d_addr[1:0]` != 0):
  - go from `IDLE` directly to `RESP_D` with `d_err` = 1 and `d_rdata` = `ERR_DATA`;
  - `mem_en` is never asserted;
  - counts as a data grant for `starve_cnt`.
- Fetch addresses are word-aligned by construction; bits [1:0] are ignored.
- `GRANT_x`:
  - `mem_en` = 1, with address, `mem_we` and `mem_wdata` stable.
  - `mem_ready` = 1: latch `mem_rdata` into `x_rdata`, go to `RESP_x`. For stores, `d_rdata` = 0.
  - Timeout counter reaches `TIMEOUT` with no `mem_ready`: go to `RESP_x` with `x_err` = 1 and `x_rdata` = `ERR_DATA`.
- `RESP_x`: `x_valid` = 1 for exactly this cycle, then go to `IDLE`. The requester must drop or replace its request by the next cycle. The one-cycle gap keeps the same request from being re-granted.
- `mem_ready` outside `GRANT_*` is ignored.

## Timing
- All outputs are registered. Reset values:
  - `mem_en`, `mem_we`, `if_valid`, `d_valid`, `if_err`, `d_err` = 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0;
  - state = `IDLE`; `starve_cnt` and timeout counter = 0.
- Access sequence:
  - Request seen in `IDLE` at cycle N.
  - `mem_en` high from N+1.
  - `mem_ready` may assert as early as N+1.
  - Valid at the cycle after `mem_ready`.
  - `IDLE` the cycle after that.
- Minimum latency: request to valid = 2 cycles; one access per 3 cycles.
- Misaligned access: request to valid = 1 cycle.
- Timeout: `mem_en` stays high for exactly `TIMEOUT` cycles, then drops; the error valid follows on the next cycle.
- Reset mid-access: everything returns to reset values immediately. `mem_en` drops asynchronously and no valid is issued.
- A request that deasserts in `IDLE` before being sampled is never served.

## Test plan
- Single fetch, `if_addr` = 0x10, memory returns 0x01098020 with 1-cycle latency:
  - `mem_en` high at N+1;
  - `if_valid` at N+2 with `if_rdata` = 0x01098020;
  - `d_valid` stays 0.
- Store with `d_addr` = 0x24, `d_wdata` = 0x55AA, 3-cycle memory latency:
  - `mem_en` and `mem_we` high for 3 cycles with `mem_addr` = 0x24;
  - `d_valid` one cycle later, `d_err` = 0.
- `if_req` and `d_req` both held continuously, `STARVE_LIMIT` = 4: grant order is D,D,D,D,IF,D,D,D,D,IF.
- Load with `d_addr` = 0x26: `d_valid` one cycle after the request with `d_err` = 1, `d_rdata` = 0xDEADBEEF; `mem_en` never asserts.
- Fetch with `mem_ready` held 0, `TIMEOUT` = 16: `mem_en` is high for exactly 16 cycles, then `if_valid` with `if_err` = 1 and `if_rdata` = 0xDEADBEEF.
- Assert `rst_n` = 0 during `GRANT_D`: `mem_en` falls immediately; after release, no stale `d_valid`, and the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-ported memory between instruction fetch
// and load/store. Data has priority; a saturating starvation counter forces fetch through.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    // state    | meaning
    // IDLE     | sample requests, pick a winner
    // GRANT_IF | fetch command on memory port, waiting for mem_ready/timeout
    // GRANT_D  | load/store command on memory port, waiting for mem_ready/timeout
    // RESP_IF  | one-cycle fetch response
    // RESP_D   | one-cycle data response (also taken directly on misalignment)
    typedef enum logic [2:0] {IDLE, GRANT_IF, GRANT_D, RESP_IF, RESP_D} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;
    logic       pick_d, pick_if, misaligned, tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pick_d     = 1'b0;
        pick_if    = 1'b0;
        misaligned = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && starve_cnt == STARVE_MAX)) begin
                    pick_d     = 1'b1;
                    misaligned = (d_addr[1:0] != 2'b00);
                    state_next = misaligned ? RESP_D : GRANT_D;
                end else if (if_req) begin
                    pick_if    = 1'b1;
                    state_next = GRANT_IF;
                end
            end
            GRANT_IF: begin
                if (mem_ready) begin
                    state_next = RESP_IF;
                end else if (tmo_cnt == 8'd0) begin
                    tmo_hit    = 1'b1;
                    state_next = RESP_IF;
                end
            end
            GRANT_D: begin
                if (mem_ready) begin
                    state_next = RESP_D;
                end else if (tmo_cnt == 8'd0) begin
                    tmo_hit    = 1'b1;
                    state_next = RESP_D;
                end
            end
            RESP_IF, RESP_D: state_next = IDLE;
            default:         state_next = IDLE;
        endcase
    end

    // Every output is a flop loaded from the next-state decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            if_valid   <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= 32'd0;
            d_valid    <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= 32'd0;
            starve_cnt <= 4'd0;
            tmo_cnt    <= 8'd0;
        end else begin
            mem_en   <= (state_next == GRANT_IF) || (state_next == GRANT_D);
            if_valid <= (state_next == RESP_IF);
            d_valid  <= (state_next == RESP_D);

            if (pick_d || pick_if)
                tmo_cnt <= TMO_LOAD;
            else if ((state == GRANT_IF || state == GRANT_D) && tmo_cnt != 8'd0)
                tmo_cnt <= tmo_cnt - 8'd1;

            if (pick_d) begin
                mem_addr  <= d_addr & ~32'd3;
                mem_wdata <= d_wdata;
                mem_we    <= d_we & ~misaligned;
            end else if (pick_if) begin
                mem_addr  <= if_addr & ~32'd3;
                mem_we    <= 1'b0;
            end else if (state_next != GRANT_D) begin
                mem_we    <= 1'b0;
            end

            if (pick_if)
                starve_cnt <= 4'd0;
            else if (pick_d)
                starve_cnt <= !if_req ? 4'd0 :
                              (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;

            if (state_next == RESP_IF) begin
                if_err   <= tmo_hit;
                if_rdata <= tmo_hit ? ERR_DATA : mem_rdata;
            end else begin
                if_err   <= 1'b0;
            end

            if (state_next == RESP_D) begin
                d_err   <= misaligned || tmo_hit;
                d_rdata <= (misaligned || tmo_hit) ? ERR_DATA : (mem_we ? 32'd0 : mem_rdata);
            end else begin
                d_err   <= 1'b0;
            end
        end
    end

endmodule
